// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button pulses in, BCD digits and status out for the stopwatch
interface stopwatch_ctrl_if;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic       running;
    logic       tick;
    logic       overflow;

    modport master (
        output start_stop, clear, lap,
        input  sec_ones, sec_tens, min_ones, running, tick, overflow
    );

    modport slave (
        input  start_stop, clear, lap,
        output sec_ones, sec_tens, min_ones, running, tick, overflow
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - M:SS stopwatch FSM, 1 s prescaler and BCD count; LAP_STOPWATCH_EN adds lap freeze
module stopwatch_ctrl #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MAX_MIN       = 9
) (
    input  logic              fastclock,
    input  logic              resetn,
    stopwatch_ctrl_if.slave   sw
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

    localparam int            PW         = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]    MIN_LAST   = 4'(MAX_MIN);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    min_q, min_d;
    logic          tick_q, tick_d;
    logic          boundary;
    logic          at_max;

    assign boundary = (state_q == RUN) && (presc_q == PRESC_LAST);
    assign at_max   = (min_q == MIN_LAST) && (tens_q == 4'd5) && (ones_q == 4'd9);

    always_ff @(posedge fastclock) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (sw.clear) begin
            state_d = IDLE;
        end else if (sw.start_stop) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = DONE;
            endcase
        end else if (boundary && at_max) begin
            state_d = DONE;
        end
    end

    // A start_stop on a boundary cycle wins: the prescaler holds at its last value,
    // so resuming produces the pending increment one cycle later.
    always_comb begin
        presc_d = presc_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        min_d   = min_q;
        tick_d  = 1'b0;
        if (sw.clear) begin
            presc_d = '0;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
            min_d   = 4'd0;
        end else if (!sw.start_stop && state_q == RUN) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                if (!at_max) begin
                    tick_d = 1'b1;
                    if (ones_q == 4'd9) begin
                        ones_d = 4'd0;
                        if (tens_q == 4'd5) begin
                            tens_d = 4'd0;
                            min_d  = min_q + 4'd1;
                        end else begin
                            tens_d = tens_q + 4'd1;
                        end
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge fastclock) begin
        if (!resetn) begin
            presc_q <= '0;
            ones_q  <= 4'd0;
            tens_q  <= 4'd0;
            min_q   <= 4'd0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            ones_q  <= ones_d;
            tens_q  <= tens_d;
            min_q   <= min_d;
            tick_q  <= tick_d;
        end
    end

    assign sw.running  = (state_q == RUN);
    assign sw.overflow = (state_q == DONE);
    assign sw.tick     = tick_q;

`ifdef LAP_STOPWATCH_EN
    logic        freeze_q, freeze_d;
    logic [11:0] disp_q, disp_d;

    // Snapshot is taken from the count before this edge's increment.
    always_comb begin
        freeze_d = freeze_q;
        disp_d   = disp_q;
        if (sw.clear) begin
            freeze_d = 1'b0;
        end else if (sw.lap && (state_q == RUN || state_q == PAUSE)) begin
            freeze_d = !freeze_q;
            if (!freeze_q) disp_d = {min_q, tens_q, ones_q};
        end
    end

    always_ff @(posedge fastclock) begin
        if (!resetn) begin
            freeze_q <= 1'b0;
            disp_q   <= '0;
        end else begin
            freeze_q <= freeze_d;
            disp_q   <= disp_d;
        end
    end

    assign sw.min_ones = freeze_q ? disp_q[11:8] : min_q;
    assign sw.sec_tens = freeze_q ? disp_q[7:4]  : tens_q;
    assign sw.sec_ones = freeze_q ? disp_q[3:0]  : ones_q;
`else
    logic lap_unused;
    assign lap_unused  = sw.lap;
    assign sw.min_ones = min_q;
    assign sw.sec_tens = tens_q;
    assign sw.sec_ones = ones_q;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - vector table, directed corner cases and random run against a seconds-count model
module tb_stopwatch_ctrl;
    localparam int TPS  = 4;
    localparam int MAXM = 9;
    localparam int MAXS = MAXM * 60 + 59;

    logic fastclock = 1'b0;
    logic resetn;
    stopwatch_ctrl_if sw();

    stopwatch_ctrl #(.TICKS_PER_SEC(TPS), .MAX_MIN(MAXM)) dut (
        .fastclock (fastclock),
        .resetn    (resetn),
        .sw        (sw)
    );

    always #5 fastclock = ~fastclock;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;

    // Model: elapsed whole seconds plus cycles into the current second.
    int m_st, m_secs, m_sub, m_tick, m_frz, m_frz_secs;

    typedef struct {
        int ss, clr, n;
        int mn, tn, on, run, ovf, ticks;
    } vec_t;
    vec_t vec [10];

    task automatic model_step();
        int nst, nsecs, nsub;
        if (!resetn) begin
            m_st = 0; m_secs = 0; m_sub = 0; m_tick = 0; m_frz = 0; m_frz_secs = 0;
        end else begin
            nst = m_st; nsecs = m_secs; nsub = m_sub; m_tick = 0;
`ifdef LAP_STOPWATCH_EN
            if (sw.clear) m_frz = 0;
            else if (sw.lap && (m_st == 1 || m_st == 2)) begin
                if (m_frz == 0) m_frz_secs = m_secs;
                m_frz = (m_frz == 0) ? 1 : 0;
            end
`endif
            if (sw.clear) begin
                nst = 0; nsecs = 0; nsub = 0;
            end else if (sw.start_stop) begin
                if (m_st == 0 || m_st == 2) nst = 1;
                else if (m_st == 1) nst = 2;
            end else if (m_st == 1) begin
                if (m_sub == TPS - 1) begin
                    nsub = 0;
                    if (m_secs == MAXS) nst = 3;
                    else begin nsecs = m_secs + 1; m_tick = 1; end
                end else nsub = m_sub + 1;
            end
            m_st = nst; m_secs = nsecs; m_sub = nsub;
        end
    endtask

    task automatic cycle();
        @(posedge fastclock);
        model_step();
        @(negedge fastclock);
        if (sw.tick) tick_cnt++;
    endtask

    task automatic pulse(input int ss, input int clr, input int lp);
        sw.start_stop = (ss != 0);
        sw.clear      = (clr != 0);
        sw.lap        = (lp != 0);
        cycle();
        sw.start_stop = 1'b0;
        sw.clear      = 1'b0;
        sw.lap        = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic check_disp(input string name, input int mn, input int tn, input int on,
                              input int run, input int ovf);
        checks++;
        if (int'(sw.min_ones) != mn || int'(sw.sec_tens) != tn || int'(sw.sec_ones) != on ||
            int'(sw.running) != run || int'(sw.overflow) != ovf) begin
            errors++;
            $display("FAIL %s: got %0d:%0d%0d run=%0d ovf=%0d, want %0d:%0d%0d run=%0d ovf=%0d",
                     name, sw.min_ones, sw.sec_tens, sw.sec_ones, sw.running, sw.overflow,
                     mn, tn, on, run, ovf);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input int cyc);
        int d;
        d = (m_frz != 0) ? m_frz_secs : m_secs;
        checks++;
        if (int'(sw.min_ones) != d / 60 || int'(sw.sec_tens) != (d / 10) % 6 ||
            int'(sw.sec_ones) != d % 10 || int'(sw.running) != int'(m_st == 1) ||
            int'(sw.overflow) != int'(m_st == 3) || int'(sw.tick) != m_tick) begin
            errors++;
            $display("FAIL random cycle %0d: got %0d:%0d%0d run=%0d ovf=%0d tick=%0d, want %0d:%0d%0d run=%0d ovf=%0d tick=%0d",
                     cyc, sw.min_ones, sw.sec_tens, sw.sec_ones, sw.running, sw.overflow, sw.tick,
                     d / 60, (d / 10) % 6, d % 10, int'(m_st == 1), int'(m_st == 3), m_tick);
        end
    endtask

    initial begin
        //          ss clr  n   mn tn on run ovf ticks
        vec[0] = '{0, 0,   0,  0, 0, 0, 0,  0,  0};
        vec[1] = '{1, 0,   40, 0, 1, 0, 1,  0,  10};
        vec[2] = '{1, 0,   20, 0, 1, 0, 0,  0,  0};
        vec[3] = '{1, 0,   3,  0, 1, 0, 1,  0,  0};
        vec[4] = '{0, 0,   0,  0, 1, 1, 1,  0,  1};
        vec[5] = '{1, 1,   0,  0, 0, 0, 0,  0,  0};
        vec[6] = '{1, 0,   8,  0, 0, 2, 1,  0,  2};
        vec[7] = '{1, 0,   0,  0, 0, 2, 0,  0,  0};
        vec[8] = '{0, 1,   2,  0, 0, 0, 0,  0,  0};
        vec[9] = '{0, 0,   5,  0, 0, 0, 0,  0,  0};

        resetn = 1'b0;
        sw.start_stop = 1'b0;
        sw.clear = 1'b0;
        sw.lap = 1'b0;
        @(negedge fastclock);
        idle(2);
        check_int("reset tick", int'(sw.tick), 0);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick_cnt = 0;
            pulse(vec[i].ss, vec[i].clr, 0);
            idle(vec[i].n);
            check_disp($sformatf("vec%0d", i), vec[i].mn, vec[i].tn, vec[i].on, vec[i].run, vec[i].ovf);
            check_int($sformatf("vec%0d ticks", i), tick_cnt, vec[i].ticks);
        end

        // Pause on the boundary cycle: no increment, prescaler keeps its last value.
        pulse(1, 0, 0);
        idle(3);
        tick_cnt = 0;
        pulse(1, 0, 0);
        check_disp("pause on boundary", 0, 0, 0, 0, 0);
        pulse(1, 0, 0);
        check_disp("resume at boundary", 0, 0, 0, 1, 0);
        pulse(0, 0, 0);
        check_disp("first cycle after resume", 0, 0, 1, 1, 0);
        check_int("boundary ticks", tick_cnt, 1);
        pulse(0, 1, 0);

        // Carries and saturation.
        pulse(1, 0, 0);
        idle(59 * TPS);
        check_disp("0:59", 0, 5, 9, 1, 0);
        idle(TPS);
        check_disp("double carry 1:00", 1, 0, 0, 1, 0);
        idle(539 * TPS);
        check_disp("9:59", 9, 5, 9, 1, 0);
        tick_cnt = 0;
        idle(TPS);
        check_disp("overflow", 9, 5, 9, 0, 1);
        check_int("no tick on overflow", tick_cnt, 0);
        pulse(1, 0, 0);
        idle(TPS);
        check_disp("done ignores start_stop", 9, 5, 9, 0, 1);
        pulse(0, 1, 0);
        check_disp("clear from done", 0, 0, 0, 0, 0);

        // Reset in the middle of a run.
        pulse(1, 0, 0);
        idle(3 * TPS);
        check_disp("run 0:03", 0, 0, 3, 1, 0);
        check_int("tick before reset", int'(sw.tick), 1);
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        check_disp("mid-run reset", 0, 0, 0, 0, 0);
        check_int("tick after reset", int'(sw.tick), 0);

        // Lap: frozen display while the count advances.
        pulse(1, 0, 0);
        idle(2 * TPS);
        check_disp("lap base 0:02", 0, 0, 2, 1, 0);
        pulse(0, 0, 1);
        idle(12);
`ifdef LAP_STOPWATCH_EN
        check_disp("lap frozen", 0, 0, 2, 1, 0);
`else
        check_disp("lap ignored", 0, 0, 5, 1, 0);
`endif
        pulse(0, 0, 1);
        check_disp("lap released", 0, 0, 5, 1, 0);
        pulse(0, 1, 0);
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        idle(TPS);
        check_disp("lap in idle ignored", 0, 0, 1, 1, 0);

        // Random pulses against the model.
        for (int c = 0; c < 3000; c++) begin
            resetn        = ($urandom_range(0, 199) != 0);
            sw.start_stop = ($urandom_range(0, 11) == 0);
            sw.clear      = ($urandom_range(0, 79) == 0);
            sw.lap        = ($urandom_range(0, 9) == 0);
            cycle();
            check_model(c);
        end
        resetn = 1'b1;
        sw.start_stop = 1'b0;
        sw.clear = 1'b0;
        sw.lap = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
